writeback_stage: RTL and testbench

//  Registered, parametrised writeback stage for the RISC-V core. Selects the result
//  (ALU / load / PC+4), aligns and sign- or zero-extends load data, suppresses writes
//  to x0, and presents one register-file write per accepted instruction through a

---
 rtl/writeback_stage_if.sv | 38 +++
 rtl/writeback_stage.sv | 106 ++++++++++
 tb/tb_writeback_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage handshake bundle: MEM-side inputs, register-file outputs.
// Ports: in_valid/in_ready, operands and load controls in; out_valid/out_ready,
//   WriteData/WriteReg/RegWriteOut out. master = driver/sink side, slave = stage.
interface writeback_stage_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       ReadData;
    logic [XLEN-1:0]       ALUResult;
    logic [XLEN-1:0]       PCPlus4;
    logic [REG_ADDR_W-1:0] Rd;
    logic [1:0]            ResultSrc;
    logic                  RegWrite;
    logic [1:0]            LoadSize;
    logic                  LoadUnsigned;
    logic [2:0]            AddrLow;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       WriteData;
    logic [REG_ADDR_W-1:0] WriteReg;
    logic                  RegWriteOut;

    modport master (
        output in_valid, ReadData, ALUResult, PCPlus4, Rd,
        output ResultSrc, RegWrite, LoadSize, LoadUnsigned, AddrLow,
        output out_ready,
        input  in_ready, out_valid, WriteData, WriteReg, RegWriteOut
    );

    modport slave (
        input  in_valid, ReadData, ALUResult, PCPlus4, Rd,
        input  ResultSrc, RegWrite, LoadSize, LoadUnsigned, AddrLow,
        input  out_ready,
        output in_ready, out_valid, WriteData, WriteReg, RegWriteOut
    );
endinterface

// File: rtl/writeback_stage.sv
// Registered writeback stage: result select, load align/extend, x0 suppression.
// Ports: clk, reset (async, active-high), bus (writeback_stage_if.slave);
//   retire_count (64-bit) only when WB_RETIRE_CNT_EN is defined.
module writeback_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]        retire_count
`endif
);

    logic                  valid_q;
    logic [XLEN-1:0]       data_q;
    logic [REG_ADDR_W-1:0] reg_q;
    logic                  we_q;

    logic                  accept;
    logic [2:0]            al;
    logic [1:0]            size;
    logic [2:0]            off;
    logic [XLEN-1:0]       sh;
    logic [XLEN-1:0]       ld;
    logic [XLEN-1:0]       data_d;

    assign bus.in_ready = !valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Offset is rounded down to the access size; RV32 has a single
    // word lane, so the upper offset bit and double size fold away.
    always_comb begin
        al   = bus.AddrLow;
        size = bus.LoadSize;
        if (XLEN == 32) begin
            al[2] = 1'b0;
            if (size == 2'b11) size = 2'b10;
        end
        off = 3'd0;
        unique case (size)
            2'b00:   off = al;
            2'b01:   off = {al[2:1], 1'b0};
            default: off = {al[2], 2'b00};
        endcase
        sh = bus.ReadData >> {off, 3'b000};
        ld = bus.ReadData;
        unique case (size)
            2'b00: ld = bus.LoadUnsigned ? XLEN'(sh[7:0])
                                         : XLEN'($signed(sh[7:0]));
            2'b01: ld = bus.LoadUnsigned ? XLEN'(sh[15:0])
                                         : XLEN'($signed(sh[15:0]));
            2'b10: ld = bus.LoadUnsigned ? XLEN'(sh[31:0])
                                         : XLEN'($signed(sh[31:0]));
            default: ld = bus.ReadData;
        endcase
    end

    // Reserved select 11 falls through to the ALU result.
    always_comb begin
        data_d = bus.ALUResult;
        unique case (1'b1)
            (bus.ResultSrc == 2'b01): data_d = ld;
            (bus.ResultSrc == 2'b10): data_d = bus.PCPlus4;
            default:                  data_d = bus.ALUResult;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            reg_q   <= '0;
            we_q    <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            reg_q   <= bus.Rd;
            we_q    <= bus.RegWrite & (bus.Rd != '0);
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if (valid_q & bus.out_ready) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_count = retire_q;
`endif

    assign bus.out_valid   = valid_q;
    assign bus.WriteData   = data_q;
    assign bus.WriteReg    = reg_q;
    assign bus.RegWriteOut = we_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors, queued expectations,
// independent monitor checking every output handshake.
module tb_writeback_stage;
    localparam int XLEN = 64;
    localparam int RW   = 5;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;
    int   cyc    = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    writeback_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    writeback_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic [4:0] r,
                                input logic w);
        exp_t e;
        e.data = d;
        e.rd   = r;
        e.we   = w;
        return e;
    endfunction

    // Monitor: every handshake must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: got %h want none",
                             bus.WriteData);
                end else begin
                    e = sbq.pop_front();
                    chk("mon_data", bus.WriteData, e.data);
                    chk("mon_reg", 64'(bus.WriteReg), 64'(e.rd));
                    chk("mon_we", 64'(bus.RegWriteOut), 64'(e.we));
                end
            end
        end
    end

    task automatic drive(input logic [63:0] rdat, input logic [63:0] alu,
                         input logic [63:0] pc, input logic [4:0] rd,
                         input logic [1:0] src, input logic rw,
                         input logic [1:0] ls, input logic lu,
                         input logic [2:0] al);
        bus.in_valid     = 1'b1;
        bus.ReadData     = rdat;
        bus.ALUResult    = alu;
        bus.PCPlus4      = pc;
        bus.Rd           = rd;
        bus.ResultSrc    = src;
        bus.RegWrite     = rw;
        bus.LoadSize     = ls;
        bus.LoadUnsigned = lu;
        bus.AddrLow      = al;
    endtask

    task automatic wait_accept(input string nm, input exp_t e);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: in_ready 0 want 1", nm);
        end else begin
            @(posedge clk);
            #1;
            sbq.push_back(e);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input string nm, input logic [63:0] rdat,
                        input logic [63:0] alu, input logic [63:0] pc,
                        input logic [4:0] rd, input logic [1:0] src,
                        input logic rw, input logic [1:0] ls,
                        input logic lu, input logic [2:0] al,
                        input exp_t e);
        drive(rdat, alu, pc, rd, src, rw, ls, lu, al);
        wait_accept(nm, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        drive('0, '0, '0, '0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0);
        bus.in_valid = 1'b0;
        idle(2);
        reset = 1'b0;

        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", bus.WriteData, 64'd0);
        chk("rst_reg", 64'(bus.WriteReg), 64'd0);
        chk("rst_we", 64'(bus.RegWriteOut), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        send("alu", 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0, 5'd7,
             2'b00, 1'b1, 2'b00, 1'b0, 3'd0,
             mk(64'hBBBB_BBBB_BBBB_BBBB, 5'd7, 1'b1));
        chk("alu_valid", 64'(bus.out_valid), 64'd1);
        chk("alu_data", bus.WriteData, 64'hBBBB_BBBB_BBBB_BBBB);
        send("lb", 64'h8000, 64'h0, 64'h0, 5'd1, 2'b01, 1'b1,
             2'b00, 1'b0, 3'd1, mk(64'hFFFF_FFFF_FFFF_FF80, 5'd1, 1'b1));
        send("lbu", 64'h8000, 64'h0, 64'h0, 5'd2, 2'b01, 1'b1,
             2'b00, 1'b1, 3'd1, mk(64'h80, 5'd2, 1'b1));
        send("lw_hi", 64'hDEAD_BEEF_1234_5678, 64'h0, 64'h0, 5'd3,
             2'b01, 1'b1, 2'b10, 1'b0, 3'd4,
             mk(64'hFFFF_FFFF_DEAD_BEEF, 5'd3, 1'b1));
        send("x0_link", 64'h0, 64'h99, 64'h1004, 5'd0, 2'b10, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'h1004, 5'd0, 1'b0));
        send("lhu_odd", 64'h1122_3344_5566_7788, 64'h0, 64'h0, 5'd4,
             2'b01, 1'b1, 2'b01, 1'b1, 3'd7, mk(64'h1122, 5'd4, 1'b1));
        send("lh", 64'h0000_0000_8001_0000, 64'h0, 64'h0, 5'd5,
             2'b01, 1'b1, 2'b01, 1'b0, 3'd2,
             mk(64'hFFFF_FFFF_FFFF_8001, 5'd5, 1'b1));
        send("ld", 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 5'd6,
             2'b01, 1'b1, 2'b11, 1'b0, 3'd5,
             mk(64'h0123_4567_89AB_CDEF, 5'd6, 1'b1));
        send("rsvd", 64'hFFFF, 64'h5555, 64'h8, 5'd8, 2'b11, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'h5555, 5'd8, 1'b1));
        send("norw", 64'h0, 64'h42, 64'h0, 5'd12, 2'b00, 1'b0,
             2'b00, 1'b0, 3'd0, mk(64'h42, 5'd12, 1'b0));
        send("lwu_lo", 64'hDEAD_BEEF_1234_5678, 64'h0, 64'h0, 5'd9,
             2'b01, 1'b1, 2'b10, 1'b1, 3'd3, mk(64'h1234_5678, 5'd9, 1'b1));
        send("lb_b7", 64'hAB00_0000_0000_0000, 64'h0, 64'h0, 5'd10,
             2'b01, 1'b1, 2'b00, 1'b0, 3'd7,
             mk(64'hFFFF_FFFF_FFFF_FFAB, 5'd10, 1'b1));
        idle(2);

        // Backpressure: A held while B waits upstream.
        bus.out_ready = 1'b0;
        send("bp_a", 64'h0, 64'hA5A5, 64'h0, 5'd3, 2'b00, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'hA5A5, 5'd3, 1'b1));
        drive(64'h0, 64'hB0B0, 64'h0, 5'd4, 2'b00, 1'b1, 2'b00, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold", bus.WriteData, 64'hA5A5);
            chk("bp_reg", 64'(bus.WriteReg), 64'd3);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept("bp_b", mk(64'hB0B0, 5'd4, 1'b1));
        chk("bp_next", bus.WriteData, 64'hB0B0);

        c0 = cyc;
        send("b2b_c", 64'h0, 64'hC, 64'h0, 5'd13, 2'b00, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'hC, 5'd13, 1'b1));
        send("b2b_d", 64'h0, 64'hD, 64'h0, 5'd14, 2'b00, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'hD, 5'd14, 1'b1));
        send("b2b_e", 64'h0, 64'hE, 64'h0, 5'd15, 2'b00, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'hE, 5'd15, 1'b1));
        chk("b2b_cycles", 64'(cyc - c0), 64'd3);
        idle(2);

        // Reset while stalled drops the held entry.
        bus.out_ready = 1'b0;
        send("rs_x", 64'h0, 64'h77, 64'h0, 5'd9, 2'b00, 1'b1,
             2'b00, 1'b0, 3'd0, mk(64'h77, 5'd9, 1'b1));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_data", bus.WriteData, 64'd0);
        chk("rs_reg", 64'(bus.WriteReg), 64'd0);
        chk("rs_we", 64'(bus.RegWriteOut), 64'd0);
        chk("rs_ready", 64'(bus.in_ready), 64'd1);
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        hs_cnt = 0;

        for (int i = 1; i <= 5; i++) begin
            send("ret", 64'h0, 64'(i), 64'h0, 5'(i), 2'b00, (i != 3),
                 2'b00, 1'b0, 3'd0, mk(64'(i), 5'(i), (i != 3)));
        end
        idle(3);
        chk("handshakes", 64'(hs_cnt), 64'd5);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_count", retire_count, 64'd5);
`endif
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
